// File: rtl/ysyx_210544_axi_io_arbiter_pkg.sv
// ysyx_210544_axi_io_arbiter_pkg: shared size codes, master indices and arbiter state type.
package ysyx_210544_axi_io_arbiter_pkg;
  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;
  localparam logic [2:0] SIZE_D = 3'd3;
  localparam logic [1:0] M_ICACHE = 2'd0;
  localparam logic [1:0] M_DCACHE = 2'd1;
  localparam logic [1:0] M_NOCACHE = 2'd2;
  typedef enum logic {IDLE, BUSY} state_t;
  function automatic logic [1:0] oh2idx(input logic [2:0] oh);
    return oh[2] ? M_NOCACHE : oh[1] ? M_DCACHE : M_ICACHE;
  endfunction
endpackage

// File: rtl/ysyx_210544_rr_pick.sv
// ysyx_210544_rr_pick: combinational 3-way round-robin or fixed-priority (m2 > m1 > m0) selector.
module ysyx_210544_rr_pick
  import ysyx_210544_axi_io_arbiter_pkg::*;
(
  input  logic [2:0] valid,
  input  logic [1:0] ptr,
  input  logic       rr_en,
  output logic [2:0] grant
);
  logic [5:0] dbl;
  logic [1:0] off;
  logic [2:0] sum;
  logic [1:0] idx;
  always_comb begin
    dbl = {valid, valid} >> ptr;
    off = dbl[0] ? 2'd0 : dbl[1] ? 2'd1 : 2'd2;
    sum = {1'b0, ptr} + {1'b0, off};
    idx = sum >= 3'd3 ? 2'(sum - 3'd3) : sum[1:0];
    grant = ~|valid ? 3'b000 :
            rr_en ? 3'b001 << idx :
            valid[M_NOCACHE] ? 3'b100 : valid[M_DCACHE] ? 3'b010 : 3'b001;
  end
endmodule

// File: rtl/ysyx_210544_axi_io_arbiter.sv
// ysyx_210544_axi_io_arbiter: 3-to-1 valid/ready arbiter in front of the AXI-io bridge port.
module ysyx_210544_axi_io_arbiter
  import ysyx_210544_axi_io_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_m0_valid,
  input  logic         i_m0_op,
  input  logic [63:0]  i_m0_addr,
  input  logic [511:0] i_m0_wdata,
  input  logic [2:0]   i_m0_size,
  input  logic [7:0]   i_m0_blks,
  output logic         o_m0_ready,
  output logic [511:0] o_m0_rdata,
  input  logic         i_m1_valid,
  input  logic         i_m1_op,
  input  logic [63:0]  i_m1_addr,
  input  logic [511:0] i_m1_wdata,
  input  logic [2:0]   i_m1_size,
  input  logic [7:0]   i_m1_blks,
  output logic         o_m1_ready,
  output logic [511:0] o_m1_rdata,
  input  logic         i_m2_valid,
  input  logic         i_m2_op,
  input  logic [63:0]  i_m2_addr,
  input  logic [511:0] i_m2_wdata,
  input  logic [2:0]   i_m2_size,
  input  logic [7:0]   i_m2_blks,
  output logic         o_m2_ready,
  output logic [511:0] o_m2_rdata,
  output logic         o_axi_io_valid,
  output logic         o_axi_io_op,
  output logic [63:0]  o_axi_io_addr,
  output logic [511:0] o_axi_io_wdata,
  output logic [2:0]   o_axi_io_size,
  output logic [7:0]   o_axi_io_blks,
  input  logic         i_axi_io_ready,
  input  logic [511:0] i_axi_io_rdata
);
  state_t     state;
  logic [1:0] gnt, ptr, win;
  logic [2:0] pick;
  logic       hs;
  ysyx_210544_rr_pick u_pick (
    .valid({i_m2_valid, i_m1_valid, i_m0_valid}),
    .ptr  (ptr),
    .rr_en(RR_EN),
    .grant(pick)
  );
  assign win = oh2idx(pick);
  assign hs = (state == BUSY) & o_axi_io_valid & i_axi_io_ready;
  assign o_m0_ready = hs & (gnt == M_ICACHE);
  assign o_m1_ready = hs & (gnt == M_DCACHE);
  assign o_m2_ready = hs & (gnt == M_NOCACHE);
  assign o_m0_rdata = i_axi_io_rdata;
  assign o_m1_rdata = i_axi_io_rdata;
  assign o_m2_rdata = i_axi_io_rdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= M_ICACHE;
      ptr <= M_ICACHE;
      o_axi_io_valid <= 1'b0;
      o_axi_io_op <= 1'b0;
      o_axi_io_addr <= '0;
      o_axi_io_wdata <= '0;
      o_axi_io_size <= '0;
      o_axi_io_blks <= '0;
    end else if (state == IDLE && |pick) begin
      state <= BUSY;
      gnt <= win;
      o_axi_io_valid <= 1'b1;
      o_axi_io_op <= win == M_NOCACHE ? i_m2_op : win == M_DCACHE ? i_m1_op : i_m0_op;
      o_axi_io_addr <= win == M_NOCACHE ? i_m2_addr : win == M_DCACHE ? i_m1_addr : i_m0_addr;
      o_axi_io_wdata <= win == M_NOCACHE ? i_m2_wdata : win == M_DCACHE ? i_m1_wdata : i_m0_wdata;
      o_axi_io_size <= win == M_NOCACHE ? i_m2_size : win == M_DCACHE ? i_m1_size : i_m0_size;
      o_axi_io_blks <= win == M_NOCACHE ? i_m2_blks : win == M_DCACHE ? i_m1_blks : i_m0_blks;
      if (RR_EN) ptr <= win == M_NOCACHE ? M_ICACHE : win + 2'd1;
    end else if (hs) begin
      state <= IDLE;
      gnt <= M_ICACHE;
      o_axi_io_valid <= 1'b0;
    end
  end
endmodule

// File: doc/ysyx_210544_axi_io_arbiter.md
Name: ysyx_210544_axi_io_arbiter

Overview:
- Three-to-one arbiter on the simple valid/ready AXI-io request interface.
- Upstream masters: m0 = icache, m1 = dcache, m2 = nocache unit.
- Downstream: the single AXI-io port of the AXI4 bridge.
- Selects one pending request, latches its payload, forwards it, and returns the completion pulse and read data to the granted master only.

Parameters:
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with m2 > m1 > m0.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_mx_valid  in  1  request valid from master x (x = 0, 1, 2; one port per master, likewise for all mx ports)
- i_mx_op  in  1  0 = read, 1 = write
- i_mx_addr  in  64  byte address
- i_mx_wdata  in  512  write data
- i_mx_size  in  3  beat size code (SIZE_B/H/W/D)
- i_mx_blks  in  8  beats minus 1
- o_mx_ready  out  1  one-cycle completion pulse to master x
- o_mx_rdata  out  512  read data to master x
- o_axi_io_valid  out  1  downstream request valid
- o_axi_io_op  out  1  latched op
- o_axi_io_addr  out  64  latched address
- o_axi_io_wdata  out  512  latched write data
- o_axi_io_size  out  3  latched size
- o_axi_io_blks  out  8  latched blks
- i_axi_io_ready  in  1  downstream completion pulse
- i_axi_io_rdata  in  512  downstream read data, valid when ready = 1

Behaviour:
- Reset values:
  - o_axi_io_valid = 0; all o_axi_io payload outputs = 0.
  - Grant = none; round-robin pointer = m0 highest priority.
  - All o_mx_ready = 0.
- Handshake: hs = o_axi_io_valid & i_axi_io_ready.
- Masters hold valid and payload until their ready pulse, then drop valid on the next edge.
- State IDLE:
  - No valid inputs: stay in IDLE.
  - One or more valid: pick the winner.
    - RR_EN = 1: the first valid master at or after the pointer, in order m0 -> m1 -> m2 -> m0.
    - RR_EN = 0: fixed priority m2 > m1 > m0.
  - At the same edge: latch the winner's op/addr/wdata/size/blks into the o_axi_io regs, set o_axi_io_valid = 1, record the grant index, go to BUSY.
  - Latency: master valid sampled at edge N; downstream valid high from edge N+1.
  - RR_EN = 1: the pointer moves to the grantee + 1, mod 3, wrapping 2 -> 0.
- State BUSY:
  - Payload regs and o_axi_io_valid stay stable until hs.
  - Input changes on any master, including the grantee, are ignored.
  - On the hs cycle, combinationally:
    - o_mx_ready = i_axi_io_ready for the granted x only; all other ready outputs stay 0.
  - At the hs edge: o_axi_io_valid <= 0, grant cleared, go to IDLE.
- Turnaround: at least one IDLE cycle between transactions. A new grant is earliest at the edge after hs, where the finished master's valid is already low.
- o_mx_rdata: i_axi_io_rdata broadcast to all masters. Masters qualify it with their own ready.
- i_axi_io_ready while not BUSY: ignored; no ready output pulses.
- Grantee drops valid mid-transaction: the transaction still completes, and ready still pulses to that master.
- Reset mid-transaction: immediate return to the reset state. Downstream valid drops at the reset edge; no ready pulse is produced.
- Simultaneous requests from all three masters with RR_EN = 1 and pointer = m0: grant order is m0, m1, m2 over three consecutive transactions.

Decomposition:
- Shared defines file: SIZE_* codes and the master-index constants (M_ICACHE = 0, M_DCACHE = 1, M_NOCACHE = 2).
- One natural sub-module: ysyx_210544_rr_pick.
  - Combinational 3-way round-robin / priority selector.
  - Inputs: valid vector, pointer, RR_EN.
  - Outputs: one-hot grant.
- Remaining logic in the top level: FSM, payload latch, ready/rdata demux.

Test Plan:
- Single read:
  - Stimulus: m2 valid, op = 0, addr = 0x1000_0000, size = SIZE_B, blks = 0; downstream returns ready two cycles after valid with rdata[63:0] = 0x41.
  - Required: o_axi_io_valid high one cycle after the request with the latched fields; o_m2_ready pulses for exactly 1 cycle with o_m2_rdata[63:0] = 0x41; o_m0_ready and o_m1_ready stay 0.
- Simultaneous requests, RR_EN = 1:
  - Stimulus: m0, m1 and m2 all valid from reset; each master drops valid after its ready.
  - Required: downstream addresses appear in order m0, m1, m2; each transaction separated by at least one idle cycle.
- Fixed priority, RR_EN = 0:
  - Stimulus: m0 and m2 both continuously re-request.
  - Required: m2 is granted every time; m0 is granted only when m2 is idle.
- Payload stability:
  - Stimulus: while BUSY on m1 (addr = 0x8000_0040, blks = 7), m1 changes addr to 0xDEAD and m0 asserts valid.
  - Required: o_axi_io_addr stays 0x8000_0040 until hs; m0 is granted only after hs.
- Stray ready:
  - Stimulus: i_axi_io_ready pulses while IDLE.
  - Required: no o_mx_ready pulse; state stays IDLE.
- Reset mid-transaction:
  - Stimulus: rst asserted while BUSY on m1.
  - Required: next cycle o_axi_io_valid = 0 and no ready pulse; after release, m0 wins ties (pointer reset).
